// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU op-code constants and the requester index type
//               used by the ALU and the two-requester ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU control codes (4-bit encoding; any other code passes operand a)
    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_ADD   = 4'b0010;
    localparam logic [3:0] c_OP_SUB   = 4'b0110;
    localparam logic [3:0] c_OP_PASSB = 4'b0111;

    // Requester index; also the encoding of the round-robin pointer
    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_id_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : 64-bit combinational ALU. AND, OR, ADD, SUB (modulo 2^64),
//               pass-b; every other control code passes operand a.
// Ports       : a, b        - 64-bit operands
//               ALUControl  - N-bit control code (op codes from alu_pkg)
//               result      - 64-bit result
//               zero        - high iff result == 0
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    input  logic [N-1:0] ALUControl,
    output logic [63:0]  result,
    output logic         zero
);

    always_comb begin
        result = a;
        case (ALUControl)
            N'(c_OP_AND):   result = a & b;
            N'(c_OP_OR):    result = a | b;
            N'(c_OP_ADD):   result = a + b;   // carry discarded
            N'(c_OP_SUB):   result = a - b;   // borrow discarded
            N'(c_OP_PASSB): result = b;
            default:        result = a;
        endcase
    end

    assign zero = (result == 64'd0);

endmodule : alu
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one ALU between two requesters with round-robin
//               arbitration and a single-entry registered response stage.
//               A new request is accepted whenever the response stage is
//               empty or being drained in the same cycle, giving one
//               operation per cycle under sustained load.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               req_valid/req_ready   - per-requester handshake (bit i = req i)
//               a0,b0,op0 / a1,b1,op1 - requester operands and ALU op code
//               rsp_valid/rsp_ready   - response handshake
//               rsp_result, rsp_zero  - registered ALU result and zero flag
//               rsp_id                - requester that issued the response
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [63:0]  a0,
    input  logic [63:0]  b0,
    input  logic [N-1:0] op0,
    input  logic [63:0]  a1,
    input  logic [63:0]  b1,
    input  logic [N-1:0] op1,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [63:0]  rsp_result,
    output logic         rsp_zero,
    output logic         rsp_id
);

    // Registered state
    logic        r_rsp_valid;
    logic [63:0] r_rsp_result;
    logic        r_rsp_zero;
    req_id_e     r_rsp_id;
    req_id_e     r_prio;        // requester favoured on the next contended cycle

    // Combinational
    logic        w_can_accept;
    logic        w_accept;
    req_id_e     w_grant;
    logic [63:0] w_alu_a;
    logic [63:0] w_alu_b;
    logic [N-1:0] w_alu_op;
    logic [63:0] w_alu_result;
    logic        w_alu_zero;

    // Stage is free when empty, or when its current content leaves this cycle
    assign w_can_accept = !r_rsp_valid || rsp_ready;

    // Grant selection: a lone requester wins outright; contention goes to
    // the pointer.
    always_comb begin
        w_grant = REQ_0;
        if (req_valid == 2'b11) begin
            w_grant = r_prio;
        end else if (req_valid[1]) begin
            w_grant = REQ_1;
        end
    end

    // Reset masks the accept so neither the pointer nor a requester sees a
    // handshake while the block is held in reset.
    assign w_accept = (|req_valid) && w_can_accept && !reset;

    always_comb begin
        req_ready = 2'b00;
        if (w_accept) begin
            if (w_grant == REQ_1) begin
                req_ready = 2'b10;
            end else begin
                req_ready = 2'b01;
            end
        end
    end

    // Operand mux in front of the shared ALU
    assign w_alu_a  = (w_grant == REQ_1) ? a1  : a0;
    assign w_alu_b  = (w_grant == REQ_1) ? b1  : b0;
    assign w_alu_op = (w_grant == REQ_1) ? op1 : op0;

    alu #(
        .N (N)
    ) u_alu (
        .a          (w_alu_a),
        .b          (w_alu_b),
        .ALUControl (w_alu_op),
        .result     (w_alu_result),
        .zero       (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= 64'd0;
            r_rsp_zero   <= 1'b0;
            r_rsp_id     <= REQ_0;
            r_prio       <= REQ_0;
        end else if (w_accept) begin
            // Accept wins over a concurrent drain: the stage is refilled
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= w_alu_result;
            r_rsp_zero   <= w_alu_zero;
            r_rsp_id     <= w_grant;
            r_prio       <= (w_grant == REQ_0) ? REQ_1 : REQ_0;
        end else if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_id     = r_rsp_id;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter: reset values,
//               single grant, round-robin, back-pressure hold, drain+accept,
//               ALU op coverage with wrap-around, reset with held response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [63:0]  a0, b0, a1, b1;
    logic [N-1:0] op0, op1;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [63:0]  rsp_result;
    logic         rsp_zero;
    logic         rsp_id;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .N (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a0         (a0),
        .b0         (b0),
        .op0        (op0),
        .a1         (a1),
        .b1         (b1),
        .op1        (op1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_id     (rsp_id)
    );

    // Requesters must hold operands while waiting for a grant
    a_hold0: assert property (@(posedge clk) disable iff (reset)
        (req_valid[0] && !req_ready[0]) |=> (!req_valid[0] || ($stable(a0) && $stable(b0) && $stable(op0))))
        else begin err_cnt++; $display("FAIL hold0: requester 0 operands changed while waiting"); end

    a_hold1: assert property (@(posedge clk) disable iff (reset)
        (req_valid[1] && !req_ready[1]) |=> (!req_valid[1] || ($stable(a1) && $stable(b1) && $stable(op1))))
        else begin err_cnt++; $display("FAIL hold1: requester 1 operands changed while waiting"); end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [63:0] r,
                           input logic z, input logic id);
        chk({tag, ".valid"},  64'(rsp_valid), 64'(v));
        chk({tag, ".result"}, rsp_result,     r);
        chk({tag, ".zero"},   64'(rsp_zero),  64'(z));
        chk({tag, ".id"},     64'(rsp_id),    64'(id));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ALU vectors for requester 0: a, b, op, expected result
    logic [63:0] va   [8] = '{64'd0, 64'd9, 64'hC, 64'hC, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'd5, 64'h55, 64'd5};
    logic [63:0] vb   [8] = '{64'd1, 64'd1, 64'hA, 64'hA, 64'd2,
                              64'h1234, 64'h1, 64'd5};
    logic [3:0]  vop  [8] = '{4'b0110, 4'b1111, 4'b0000, 4'b0001, 4'b0010,
                              4'b0111, 4'b0011, 4'b0110};
    logic [63:0] vexp [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd9, 64'h8, 64'hE, 64'd1,
                              64'h1234, 64'h55, 64'd0};

    initial begin
        logic [1:0]  exp_rdy;
        logic [63:0] exp_res;
        logic        exp_id;

        // Reset with both requests and rsp_ready asserted
        reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        step(); step();
        chk("rst.req_ready", 64'(req_ready), 64'(2'b00));
        chk_rsp("rst", 1'b0, 64'd0, 1'b0, 1'b0);

        // Single requester: 5 + 3
        reset = 1'b0; req_valid = 2'b01; a0 = 64'd5; b0 = 64'd3; op0 = 4'b0010;
        #1 chk("add.req_ready", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = 2'b00;
        chk_rsp("add", 1'b1, 64'd8, 1'b0, 1'b0);
        #1 chk("drain.req_ready", 64'(req_ready), 64'(2'b00));
        step();
        chk("drain.valid", 64'(rsp_valid), 64'd0);
        step();
        chk("idle_ready.valid", 64'(rsp_valid), 64'd0);

        // Fresh reset so the pointer favours requester 0 again
        reset = 1'b1; step(); reset = 1'b0;

        // Contention: grants alternate 0,1,0,1
        a0 = 64'd7; b0 = 64'd7; op0 = 4'b0110;
        a1 = 64'hF0; b1 = 64'h0F; op1 = 4'b0001;
        req_valid = 2'b11; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id  = (i % 2 == 1);
            exp_rdy = exp_id ? 2'b10 : 2'b01;
            exp_res = exp_id ? 64'hFF : 64'd0;
            #1 chk("rr.req_ready", 64'(req_ready), 64'(exp_rdy));
            step();
            chk_rsp("rr", 1'b1, exp_res, !exp_id, exp_id);
        end

        // Back-pressure: response holds, no grants
        rsp_ready = 1'b0;
        #1 chk("bp.req_ready", 64'(req_ready), 64'(2'b00));
        for (int i = 0; i < 3; i++) begin
            step();
            chk_rsp("bp", 1'b1, 64'hFF, 1'b0, 1'b1);
            chk("bp.req_ready_hold", 64'(req_ready), 64'(2'b00));
        end

        // Drain and accept in the same cycle
        rsp_ready = 1'b1;
        #1 chk("drain_acc.req_ready", 64'(req_ready), 64'(2'b01));
        step();
        chk_rsp("drain_acc", 1'b1, 64'd0, 1'b1, 1'b0);

        // ALU op coverage, back-to-back from requester 0
        req_valid = 2'b01;
        for (int i = 0; i < 8; i++) begin
            a0 = va[i]; b0 = vb[i]; op0 = vop[i];
            #1 chk("op.req_ready", 64'(req_ready), 64'(2'b01));
            step();
            chk_rsp("op", 1'b1, vexp[i], (vexp[i] == 64'd0), 1'b0);
        end

        // Hold a response, then reset over it
        rsp_ready = 1'b0; req_valid = 2'b11;
        a0 = 64'd5; b0 = 64'd3; op0 = 4'b0010;
        #1 chk("held.req_ready", 64'(req_ready), 64'(2'b00));
        step();
        chk("held.valid", 64'(rsp_valid), 64'd1);
        reset = 1'b1;
        #1 chk("rst_held.req_ready", 64'(req_ready), 64'(2'b00));
        step();
        chk_rsp("rst_held", 1'b0, 64'd0, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        step();
        chk("rst_prec.valid", 64'(rsp_valid), 64'd0);
        reset = 1'b0; rsp_ready = 1'b0;
        #1 chk("post_rst.req_ready", 64'(req_ready), 64'(2'b01));
        step();
        chk_rsp("post_rst", 1'b1, 64'd8, 1'b0, 1'b0);

        req_valid = 2'b00;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 4, width of the ALU control code.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; bit i is high in the cycle requester i's request is accepted.
REQ-006 a0, b0  input  64 each  requester 0 operands.
REQ-007 op0  input  N  requester 0 ALU control code.
REQ-008 a1, b1  input  64 each  requester 1 operands.
REQ-009 op1  input  N  requester 1 ALU control code.
REQ-010 rsp_valid  output  1  response register holds a valid result.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_result  output  64  registered ALU result.
REQ-013 rsp_zero  output  1  registered zero flag, high iff rsp_result equals 0.
REQ-014 rsp_id  output  1  index of the requester that issued the response.

Function
REQ-015 The block SHALL share one ALU between two requesters with a single-entry registered response stage.
REQ-016 The block SHALL accept a request when at least one req_valid bit is high and the response stage is empty (rsp_valid low) or draining (rsp_valid and rsp_ready both high).
REQ-017 At most one req_ready bit SHALL be high per cycle; req_ready SHALL be combinational from req_valid, rsp_valid, rsp_ready and the priority pointer.
REQ-018 With one requester valid, that requester SHALL be granted.
REQ-019 With both valid, the requester not granted most recently SHALL be granted (round-robin); the pointer SHALL update only on an accept.
REQ-020 On accept, the granted operands and op SHALL pass through the ALU; result, zero flag and id SHALL be captured, and rsp_valid SHALL be high the next cycle (latency 1 cycle).
REQ-021 ALU op codes: 0000 a AND b; 0001 a OR b; 0010 a+b; 0110 a-b; 0111 pass b; any other code pass a.
REQ-022 Add and subtract SHALL be 64-bit modulo (wrap-around); carry and overflow are discarded.
REQ-023 While rsp_valid is high and rsp_ready low, rsp_result, rsp_zero and rsp_id SHALL hold stable, and both req_ready bits SHALL be low.
REQ-024 If rsp_ready is high while rsp_valid is high and no request is accepted, rsp_valid SHALL go low next cycle.
REQ-025 A drain and an accept in the same cycle SHALL both take effect, so sustained throughput is one operation per cycle.
REQ-026 rsp_ready while rsp_valid is low SHALL have no effect.
REQ-027 A requester SHALL hold its operands and op stable while req_valid is high and req_ready is low; the bench checks this as an assertion.

Reset
REQ-028 While reset is high: rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, req_ready=00.
REQ-029 After reset the priority pointer SHALL favour requester 0 on the first contended cycle.
REQ-030 Reset asserted while a response is held SHALL discard that response without a handshake.
REQ-031 Reset SHALL take precedence over any accept or drain in the same cycle.

Structure
REQ-032 The op-code constants (AND, OR, ADD, SUB, PASSB) SHALL live in a shared package, alu_pkg, which the existing ALU and this block both use.
REQ-033 The block SHALL instantiate the existing module alu (N=4) once as its only sub-module; the arbiter drives its a, b and ALUControl inputs through a mux.
REQ-034 The block SHALL capture the ALU zero output into rsp_zero.

Verification
REQ-035 Reset, then req_valid=01, a0=5, b0=3, op0=0010, rsp_ready=1 -> req_ready=01; next cycle rsp_valid=1, rsp_result=8, rsp_zero=0, rsp_id=0.
REQ-036 Both requests held valid (op0=0110, a0=b0=7; op1=0001, a1=0xF0, b1=0x0F), rsp_ready=1 -> grants alternate 0,1,0,1; results alternate 0 with zero=1, then 0xFF with zero=0.
REQ-037 Result held, rsp_ready=0 for 3 cycles with requests valid -> req_ready=00 and response outputs stable; rsp_ready=1 -> drain plus new accept in the same cycle, rsp_valid stays 1.
REQ-038 a0=0, b0=1, op0=0110 -> rsp_result=0xFFFF_FFFF_FFFF_FFFF, rsp_zero=0; op0=1111, a0=9 -> rsp_result=9.
REQ-039 Reset pulsed while rsp_valid=1, rsp_ready=0 -> next cycle rsp_valid=0, outputs 0, and a contended request is granted to requester 0.
